ram_dma_ci_gen2: RTL

- Parametrised successor to the custom-instruction scratchpad RAM; sits on the CPU custom-instruction (CI) interface.
- Supports word read and write, plus two DMA-style bulk operations that run autonomously inside the block:
  - FILL: write a pattern to a range of words.
  - COPY: copy a block from one address to another within the scratchpad.
- Depth is parametrised. Bulk operations hold done low until complete, which stalls the CPU.

---
 rtl/ram_dma_ci_gen2.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ram_dma_ci_gen2.sv
// ram_dma_ci_gen2: CI scratchpad RAM with word read/write plus autonomous FILL and COPY bulk operations.
// Define RAM_DMA_CI_MEMMOVE_EN to run overlapping forward copies descending (memmove semantics).
module ram_dma_ci_gen2 #(
    parameter logic [7:0] CUSTOM_ID  = 8'h0D,
    parameter int         ADDR_WIDTH = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(2 ** ADDR_WIDTH);
    localparam logic [2:0] OP_READ = 3'd0, OP_WRITE = 3'd1, OP_SETLEN = 3'd2, OP_FILL = 3'd3,
                           OP_COPY = 3'd4, OP_STATUS = 3'd5;

    typedef enum logic [2:0] {IDLE, SINGLE, FILL, COPY_PRIME, COPY, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, src_q, src_d, raddr, waddr;
    logic [LW-1:0]         cnt_q, cnt_d, len_q, len_d, sat_len;
    logic [31:0]           data_q, data_d, result_q, result_d, rdata_q, wdata;
    logic [2:0]            op_q, op_d;
    logic                  done_q, done_d, we, accept, rev_q, rev_d;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  unused_bits;

    assign accept      = start && iseId == CUSTOM_ID && state_q == IDLE;
    assign unused_bits = ^valueA[28:ADDR_WIDTH];
    assign done        = done_q;
    assign result      = result_q;

`ifdef RAM_DMA_CI_MEMMOVE_EN
    logic [ADDR_WIDTH-1:0] diff;
    // A forward-overlapping copy would clobber unread source words, so walk it top-down.
    assign diff  = valueA[ADDR_WIDTH-1:0] - valueB[ADDR_WIDTH-1:0];
    assign rev_d = accept ? (valueA[31:29] == OP_COPY && diff != '0 && LW'(diff) < len_q) : rev_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rev_q <= 1'b0;
        else       rev_q <= rev_d;
    end
`else
    assign rev_d = 1'b0;
    assign rev_q = 1'b0;
`endif

    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a, input logic r);
        return r ? a - ADDR_WIDTH'(1) : a + ADDR_WIDTH'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        data_d   = data_q;
        op_d     = op_q;
        done_d   = 1'b0;
        result_d = '0;
        we       = 1'b0;
        waddr    = addr_q;
        wdata    = data_q;
        raddr    = src_q;
        sat_len  = (|data_q[31:LW] || data_q[LW-1:0] > DEPTH_L) ? DEPTH_L : data_q[LW-1:0];
        case (state_q)
            IDLE: begin
                raddr = valueA[ADDR_WIDTH-1:0];
                if (accept) begin
                    op_d   = valueA[31:29];
                    addr_d = valueA[ADDR_WIDTH-1:0];
                    src_d  = valueB[ADDR_WIDTH-1:0];
                    data_d = valueB;
                    cnt_d  = len_q;
                    if (rev_d) begin
                        addr_d = valueA[ADDR_WIDTH-1:0] + len_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                        src_d  = valueB[ADDR_WIDTH-1:0] + len_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                    end
                    state_d = (len_q == '0 || !(op_d inside {OP_FILL, OP_COPY})) ? SINGLE :
                              (op_d == OP_FILL) ? FILL : COPY_PRIME;
                end
            end
            SINGLE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                we       = op_q == OP_WRITE;
                len_d    = (op_q == OP_SETLEN) ? sat_len : len_q;
                result_d = (op_q == OP_READ)   ? rdata_q :
                           (op_q == OP_SETLEN) ? 32'(sat_len) :
                           (op_q inside {OP_FILL, OP_COPY, OP_STATUS}) ? 32'(len_q) : '0;
            end
            FILL: begin
                we      = 1'b1;
                addr_d  = step(addr_q, 1'b0);
                cnt_d   = cnt_q - LW'(1);
                state_d = (cnt_q == LW'(1)) ? DONE : FILL;
            end
            COPY_PRIME: begin
                src_d   = step(src_q, rev_q);
                state_d = COPY;
            end
            COPY: begin
                we      = 1'b1;
                wdata   = rdata_q;
                addr_d  = step(addr_q, rev_q);
                src_d   = step(src_q, rev_q);
                cnt_d   = cnt_q - LW'(1);
                state_d = (cnt_q == LW'(1)) ? DONE : COPY;
            end
            DONE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = 32'(len_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
            len_q    <= LW'(1);
            data_q   <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            data_q   <= data_d;
            op_q     <= op_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Write-first forwarding lets an ascending overlapped copy see the word it just wrote.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule
